// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller for an 8-row LED matrix: prescaled row stepping, inter-frame
// blanking, frame-aligned direction capture and a slow mouth open/closed toggle.
module matrix_scan_ctrl #(
  parameter int SCAN_DIV     = 2500,
  parameter int BLANK_TICKS  = 1,
  parameter int MOUTH_FRAMES = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] dir_in,
  input  logic       dir_valid,
  output logic       dir_ack,
  output logic [1:0] dir_cur,
  output logic [2:0] row_idx,
  output logic [7:0] row_sel,
  output logic       blank,
  output logic       scan_tick,
  output logic       frame_done,
  output logic       mouth_state
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam int FW = (MOUTH_FRAMES > 1) ? $clog2(MOUTH_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [FW-1:0] FRAME_LAST = FW'(MOUTH_FRAMES - 1);
  localparam logic [7:0]    ROWS_OFF   = 8'hFF;
  localparam logic [7:0]    ROW0_ON    = 8'h7F;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [BW-1:0] r_blank_cnt;
  logic [FW-1:0] r_frame_cnt;
  logic [2:0]    r_row_idx;
  logic [7:0]    r_row_sel;
  logic          r_blank;
  logic          r_scan_tick;
  logic          r_frame_done;
  logic          r_dir_ack;
  logic [1:0]    r_dir_cur;
  logic          r_mouth;

  logic          w_wrap;
  logic          w_frame_end;
  logic          w_capture;
  logic [PW-1:0] w_pre_inc;
  logic [2:0]    w_row_inc;
  logic [7:0]    w_dec_next;

  assign w_wrap      = (r_pre == PRE_LAST);
  assign w_pre_inc   = r_pre + 1'b1;
  assign w_row_inc   = r_row_idx + 3'd1;
  assign w_frame_end = enable && (r_state == ST_SCAN) && w_wrap && (r_row_idx == 3'd7);
  // Direction only changes at a frame boundary or while the display is parked.
  assign w_capture   = dir_valid && !r_dir_ack && ((r_state == ST_HOLD) || w_frame_end);

  // Active-low one-cold decode of the next row; row 0 drives the MSB low.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_row_dec
      assign w_dec_next[gi] = (w_row_inc != 3'(7 - gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_HOLD;
      r_pre        <= '0;
      r_blank_cnt  <= '0;
      r_frame_cnt  <= '0;
      r_row_idx    <= 3'd0;
      r_row_sel    <= ROWS_OFF;
      r_blank      <= 1'b1;
      r_scan_tick  <= 1'b0;
      r_frame_done <= 1'b0;
      r_dir_ack    <= 1'b0;
      r_dir_cur    <= 2'd0;
      r_mouth      <= 1'b0;
    end else begin
      r_scan_tick  <= 1'b0;
      r_frame_done <= 1'b0;
      r_dir_ack    <= 1'b0;

      if (w_capture) begin
        r_dir_cur <= dir_in;
        r_dir_ack <= 1'b1;
      end

      if (!enable) begin
        // Parking keeps direction, mouth phase and frame count intact.
        r_state     <= ST_HOLD;
        r_pre       <= '0;
        r_blank_cnt <= '0;
        r_row_idx   <= 3'd0;
        r_row_sel   <= ROWS_OFF;
        r_blank     <= 1'b1;
      end else begin
        case (r_state)
          ST_HOLD: begin
            r_state   <= ST_SCAN;
            r_pre     <= '0;
            r_row_idx <= 3'd0;
            r_row_sel <= ROW0_ON;
            r_blank   <= 1'b0;
          end

          ST_SCAN: begin
            r_pre <= w_wrap ? '0 : w_pre_inc;
            if (w_wrap) begin
              r_scan_tick <= 1'b1;
              if (r_row_idx == 3'd7) begin
                r_frame_done <= 1'b1;
                r_row_idx    <= 3'd0;
                if (r_frame_cnt == FRAME_LAST) begin
                  r_frame_cnt <= '0;
                  r_mouth     <= ~r_mouth;
                end else begin
                  r_frame_cnt <= r_frame_cnt + 1'b1;
                end
                if (BLANK_TICKS > 0) begin
                  r_state     <= ST_BLANK;
                  r_blank_cnt <= '0;
                  r_row_sel   <= ROWS_OFF;
                  r_blank     <= 1'b1;
                end else begin
                  r_row_sel <= ROW0_ON;
                end
              end else begin
                r_row_idx <= w_row_inc;
                r_row_sel <= w_dec_next;
              end
            end
          end

          ST_BLANK: begin
            r_pre <= w_wrap ? '0 : w_pre_inc;
            if (w_wrap) begin
              r_scan_tick <= 1'b1;
              if (r_blank_cnt == BLANK_LAST) begin
                r_state   <= ST_SCAN;
                r_row_idx <= 3'd0;
                r_row_sel <= ROW0_ON;
                r_blank   <= 1'b0;
              end else begin
                r_blank_cnt <= r_blank_cnt + 1'b1;
              end
            end
          end

          default: begin
            r_state   <= ST_HOLD;
            r_pre     <= '0;
            r_row_idx <= 3'd0;
            r_row_sel <= ROWS_OFF;
            r_blank   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign dir_ack     = r_dir_ack;
  assign dir_cur     = r_dir_cur;
  assign row_idx     = r_row_idx;
  assign row_sel     = r_row_sel;
  assign blank       = r_blank;
  assign scan_tick   = r_scan_tick;
  assign frame_done  = r_frame_done;
  assign mouth_state = r_mouth;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: cycle-position model plus directed literal checkpoints.
module tb_matrix_scan_ctrl;

  localparam int D  = 4;
  localparam int BT = 1;
  localparam int MF = 2;
  localparam int L  = (8 + BT) * D;
  localparam int FD_POS = (8 * D) % L;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable;
  logic [1:0] dir_in;
  logic       dir_valid;
  logic       dir_ack;
  logic [1:0] dir_cur;
  logic [2:0] row_idx;
  logic [7:0] row_sel;
  logic       blank;
  logic       scan_tick;
  logic       frame_done;
  logic       mouth_state;

  int n_checks = 0;
  int n_fail   = 0;
  int k;

  matrix_scan_ctrl #(
    .SCAN_DIV(D),
    .BLANK_TICKS(BT),
    .MOUTH_FRAMES(MF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .dir_in(dir_in),
    .dir_valid(dir_valid),
    .dir_ack(dir_ack),
    .dir_cur(dir_cur),
    .row_idx(row_idx),
    .row_sel(row_sel),
    .blank(blank),
    .scan_tick(scan_tick),
    .frame_done(frame_done),
    .mouth_state(mouth_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position within the frame period since scanning started.
  bit         m_hold;
  int         m_c;
  int         m_frames;
  logic       m_tick;
  logic       m_fd;
  logic       m_ack;
  logic [1:0] m_cur;
  bit         m_was_hold;
  int         m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 1; m_c = 0; m_frames = 0;
      m_tick = 0; m_fd = 0; m_ack = 0; m_cur = 2'd0;
    end else begin
      m_was_hold = m_hold;
      m_tick = 0;
      m_fd = 0;
      if (!enable) begin
        m_hold = 1; m_c = 0;
      end else if (m_hold) begin
        m_hold = 0; m_c = 0;
      end else begin
        m_c++;
        m_p = m_c % L;
        m_tick = ((m_p % D) == 0);
        m_fd = (m_p == FD_POS);
        if (m_fd) m_frames++;
      end
      if (dir_valid && !m_ack && (m_was_hold || m_fd)) begin
        m_ack = 1; m_cur = dir_in;
      end else begin
        m_ack = 0;
      end
    end
  end

  int         c_p;
  int         c_slot;
  logic [2:0] e_row;
  logic [7:0] e_sel;
  logic       e_blank;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (m_hold) begin
        e_row = 3'd0; e_sel = 8'hFF; e_blank = 1'b1;
      end else begin
        c_p = m_c % L;
        c_slot = c_p / D;
        if (c_slot < 8) begin
          e_row = 3'(c_slot);
          e_sel = 8'hFF ^ (8'h80 >> c_slot);
          e_blank = 1'b0;
        end else begin
          e_row = 3'd0; e_sel = 8'hFF; e_blank = 1'b1;
        end
      end
      check("mdl_row_idx", 8'(row_idx), 8'(e_row));
      check("mdl_row_sel", row_sel, e_sel);
      check("mdl_blank", 8'(blank), 8'(e_blank));
      check("mdl_scan_tick", 8'(scan_tick), 8'(m_tick));
      check("mdl_frame_done", 8'(frame_done), 8'(m_fd));
      check("mdl_dir_ack", 8'(dir_ack), 8'(m_ack));
      check("mdl_dir_cur", 8'(dir_cur), 8'(m_cur));
      check("mdl_mouth", 8'(mouth_state), 8'((m_frames / MF) % 2));
    end
  end

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_row_sel"}, row_sel, 8'hFF);
    check({tag, "_row_idx"}, 8'(row_idx), 8'h00);
    check({tag, "_blank"}, 8'(blank), 8'h01);
    check({tag, "_scan_tick"}, 8'(scan_tick), 8'h00);
    check({tag, "_frame_done"}, 8'(frame_done), 8'h00);
    check({tag, "_dir_ack"}, 8'(dir_ack), 8'h00);
    check({tag, "_dir_cur"}, 8'(dir_cur), 8'h00);
    check({tag, "_mouth"}, 8'(mouth_state), 8'h00);
  endtask

  logic [7:0] tab [10] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFF, 8'h7F};

  initial begin
    enable = 1'b0;
    dir_valid = 1'b0;
    dir_in = 2'd0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("rst_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    k = -1;

    // First frame plus blank, then row 0 again
    for (int i = 0; i <= 36; i++) begin
      step();
      check("lit_row_sel", row_sel, tab[i / 4]);
      check("lit_frame_done", 8'(frame_done), 8'(i == 32));
      check("lit_scan_tick", 8'(scan_tick), 8'((i > 0) && (i % 4 == 0)));
    end

    // Direction request raised at row 2 of the second frame
    run_to(44);
    dir_valid = 1'b1;
    dir_in = 2'd3;
    while (k < 67) begin
      step();
      check("lit_ack_wait", 8'(dir_ack), 8'h00);
      check("lit_cur_wait", 8'(dir_cur), 8'h00);
    end
    check("lit_mouth_k67", 8'(mouth_state), 8'h00);
    step();
    check("lit_fd_k68", 8'(frame_done), 8'h01);
    check("lit_ack_k68", 8'(dir_ack), 8'h01);
    check("lit_cur_k68", 8'(dir_cur), 8'h03);
    check("lit_mouth_k68", 8'(mouth_state), 8'h01);
    dir_valid = 1'b0;
    step();
    check("lit_ack_k69", 8'(dir_ack), 8'h00);
    check("lit_cur_k69", 8'(dir_cur), 8'h03);

    run_to(103);
    check("lit_mouth_k103", 8'(mouth_state), 8'h01);
    step();
    check("lit_fd_k104", 8'(frame_done), 8'h01);
    check("lit_mouth_k104", 8'(mouth_state), 8'h01);
    run_to(139);
    check("lit_mouth_k139", 8'(mouth_state), 8'h01);
    step();
    check("lit_fd_k140", 8'(frame_done), 8'h01);
    check("lit_mouth_k140", 8'(mouth_state), 8'h00);
    run_to(176);
    check("lit_fd_k176", 8'(frame_done), 8'h01);

    // Park the display at row 5 of frame six
    run_to(201);
    check("lit_row_idx_k201", 8'(row_idx), 8'h05);
    check("lit_row_sel_k201", row_sel, 8'hFB);
    enable = 1'b0;
    step();
    check("lit_hold_row_sel", row_sel, 8'hFF);
    check("lit_hold_row_idx", 8'(row_idx), 8'h00);
    check("lit_hold_blank", 8'(blank), 8'h01);
    check("lit_hold_tick", 8'(scan_tick), 8'h00);
    check("lit_hold_mouth", 8'(mouth_state), 8'h00);
    check("lit_hold_cur", 8'(dir_cur), 8'h03);

    run_to(204);
    dir_valid = 1'b1;
    dir_in = 2'd2;
    step();
    check("lit_hold_ack", 8'(dir_ack), 8'h01);
    check("lit_hold_cur2", 8'(dir_cur), 8'h02);
    dir_valid = 1'b0;
    step();
    check("lit_hold_ack_drop", 8'(dir_ack), 8'h00);
    check("lit_hold_cur2_keep", 8'(dir_cur), 8'h02);

    run_to(208);
    enable = 1'b1;
    step();
    check("lit_reen_row_sel", row_sel, 8'h7F);
    check("lit_reen_row_idx", 8'(row_idx), 8'h00);
    check("lit_reen_blank", 8'(blank), 8'h00);
    check("lit_reen_mouth", 8'(mouth_state), 8'h00);
    run_to(240);
    check("lit_mouth_k240", 8'(mouth_state), 8'h00);
    step();
    check("lit_fd_k241", 8'(frame_done), 8'h01);
    check("lit_mouth_k241", 8'(mouth_state), 8'h01);

    // Asynchronous reset between clock edges while scanning
    run_to(250);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("lit_post_rst_row_sel", row_sel, 8'h7F);
    check("lit_post_rst_mouth", 8'(mouth_state), 8'h00);
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 2500: clk cycles per row-scan tick; legal range 2 or more.
REQ-002 Parameter BLANK_TICKS, default 1: ticks of all-rows-off between frames; 0 means no blank period.
REQ-003 Parameter MOUTH_FRAMES, default 25: frames per mouth_state toggle; legal range 1 or more.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  level; 1 = scan the display, 0 = hold with display dark.
REQ-007 dir_in  in  2  requested direction: 0=w, 1=s, 2=a, 3=d.
REQ-008 dir_valid  in  1  level; requester holds it high until it sees dir_ack.
REQ-009 dir_ack  out  1  one-cycle pulse; dir_in has been captured.
REQ-010 dir_cur  out  2  direction in use by the display datapath.
REQ-011 row_idx  out  3  current row index, used to address the glyph tables.
REQ-012 row_sel  out  8  active-low one-cold row drive (row0=01111111 ... row7=11111110).
REQ-013 blank  out  1  1 while row_sel is 11111111.
REQ-014 scan_tick  out  1  one-cycle pulse per prescaler wrap.
REQ-015 frame_done  out  1  one-cycle pulse when row 7 completes.
REQ-016 mouth_state  out  1  0 = mouth open, 1 = mouth closed; feeds the display state input.

Function
REQ-017 Prescaler SHALL count 0..SCAN_DIV-1 while enable=1, then wrap to 0.
REQ-018 scan_tick SHALL be registered high for exactly the cycle after the count equals SCAN_DIV-1.
REQ-019 Prescaler SHALL be forced to 0 while the FSM is in HOLD.
REQ-020 FSM states SHALL be HOLD, SCAN and BLANK; reset state SHALL be HOLD.
REQ-021 HOLD->SCAN SHALL occur on the first edge with enable=1; row_idx SHALL be 0 on entry.
REQ-022 In SCAN, each tick SHALL advance row_idx by 1.
REQ-023 In SCAN, on the tick at row_idx=7, row_idx SHALL go to 0 and frame_done SHALL pulse for one cycle.
REQ-024 On that frame-end tick, the FSM SHALL go to BLANK if BLANK_TICKS>0, else remain in SCAN.
REQ-025 BLANK SHALL persist for BLANK_TICKS ticks, then return to SCAN with row_idx=0.
REQ-026 Any state with enable=0 SHALL go to HOLD on the next edge: row_idx=0, row_sel=11111111, blank=1.
REQ-027 Entry to HOLD SHALL retain mouth_state, the frame counter and dir_cur.
REQ-028 row_sel SHALL be the registered decode of row_idx in SCAN and 11111111 otherwise, updated on the same edge as row_idx so the two never disagree.
REQ-029 Direction capture SHALL occur at the edge where frame_done is asserted, or on any edge in HOLD, when dir_valid=1 and dir_ack=0.
REQ-030 A capture SHALL load dir_cur<=dir_in and set dir_ack=1 for one cycle on the same edge.
REQ-031 dir_cur SHALL never change mid-frame.
REQ-032 If dir_valid is still high at the next frame end, it SHALL be recaptured (idempotent).
REQ-033 Frame counter SHALL increment on each frame_done.
REQ-034 On frame_done with the frame counter at MOUTH_FRAMES-1, mouth_state SHALL toggle and the counter SHALL clear.
REQ-035 scan_tick and frame_done SHALL be 0 in HOLD.
REQ-036 frame_done SHALL coincide with the scan_tick cycle of the row-7 wrap.

Reset
REQ-037 rst_n=0 SHALL immediately, without waiting for clk, force the following outputs:
- state HOLD, prescaler 0, row_idx 0, row_sel 11111111, blank 1
- scan_tick 0, frame_done 0, dir_ack 0, dir_cur 0, mouth_state 0, frame counter 0
REQ-038 After rst_n deasserts, the first state change SHALL occur on the next rising edge of clk.

Verification (SCAN_DIV=4, BLANK_TICKS=1, MOUTH_FRAMES=2)
REQ-039 Reset, then enable=1: row_sel steps 7F,BF,DF,EF,F7,FB,FD,FE, each 4 cycles; frame_done pulses once; then FF for 4 cycles; then 7F again.
REQ-040 dir_valid=1 with dir_in=3 raised at row 2: dir_ack stays 0 until the frame_done edge; then dir_ack=1 for one cycle and dir_cur=3; dir_cur is unchanged earlier.
REQ-041 Four consecutive frames: mouth_state goes 0->1 at the 2nd frame_done and 1->0 at the 4th.
REQ-042 enable=0 at row 5: next edge gives HOLD, row_sel=FF, row_idx=0; re-enable restarts at row 0 with mouth_state unchanged.
REQ-043 rst_n pulsed low between edges during SCAN: all outputs reach reset values before the next edge.
REQ-044 In HOLD, dir_valid=1 with dir_in=2: dir_ack=1 and dir_cur=2 on the next edge.
